// File: rtl/mux4_arb_pkg.sv
// Shared types, sizes and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mux_4to1_1b.sv
// 4:1 single-bit multiplexer shared by the arbitrated lane.
module mux_4to1_1b (
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic [1:0] s,
   output logic       y
);

   always_comb begin
      y = a;
      case (s)
         2'd0: y = a;
         2'd1: y = b;
         2'd2: y = c;
         2'd3: y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit scanning ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   logic [SEL_W-1:0] cand;

   // Scan from lowest priority to highest so the last hit wins.
   always_comb begin
      idx  = ptr;
      any  = 1'b0;
      cand = ptr;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 1-bit mux onto a valid/ready stream.
// Optional macro ARB_LOCK_EN adds a lock input that suppresses hold-limit rotation.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   din,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [SEL_W-1:0]     sel,
   output logic                 dout,
   output logic                 dout_valid,
   input  logic                 dout_ready
`ifdef ARB_LOCK_EN
   ,
   input  logic                 lock
`endif
);

   localparam logic [CNT_W:0]   HOLD_EXT = (CNT_W+1)'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   arb_state_t           state, state_nx;
   logic [SEL_W-1:0]     sel_nx;
   logic [SEL_W-1:0]     ptr, ptr_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx, cnt_next;
   logic [CNT_W:0]       cnt_sum;
   logic [NUM_REQ-1:0]   others;
   logic [SEL_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 xfer, stall, rotate_ok, hold_expired, release_own;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   mux_4to1_1b u_mux (
      .a (din[0]),
      .b (din[1]),
      .c (din[2]),
      .d (din[3]),
      .s (sel),
      .y (dout)
   );

`ifdef ARB_LOCK_EN
   assign rotate_ok = !lock;
`else
   assign rotate_ok = 1'b1;
`endif

   assign gnt        = (state == GRANT) ? onehot(sel) : '0;
   assign dout_valid = (state == GRANT) && req[sel];
   assign xfer       = dout_valid && dout_ready;
   assign stall      = dout_valid && !dout_ready;
   assign others     = req & ~onehot(sel);

   // Extra bit keeps cnt+1 from wrapping when MAX_HOLD fills the counter.
   assign cnt_sum  = {1'b0, cnt} + (CNT_W+1)'(xfer);
   assign cnt_next = (cnt_sum >= HOLD_EXT) ? HOLD_MAX : cnt_sum[CNT_W-1:0];

   assign hold_expired = rotate_ok && (cnt_next == HOLD_MAX) && (others != '0);
   assign release_own  = !stall && (!req[sel] || hold_expired);

   // In GRANT ptr always equals sel, so the single picker already ranks the
   // current owner last when choosing the next one.
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nx = GRANT;
               sel_nx   = pick_idx;
               ptr_nx   = pick_idx;
               cnt_nx   = '0;
            end
         end
         GRANT: begin
            if (release_own) begin
               cnt_nx = '0;
               if (others != '0) begin
                  sel_nx = pick_idx;
                  ptr_nx = pick_idx;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt_next;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         ptr   <= SEL_W'(NUM_REQ - 1);
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios then random traffic vs a reference model.
module tb_mux4_rr_arbiter;

   localparam int MAXH = 4;
`ifdef ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, din, gnt;
   logic [1:0] sel;
   logic       dout, dout_valid, dout_ready, lock;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .gnt        (gnt),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef ARB_LOCK_EN
      ,
      .lock       (lock)
`endif
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       dout;
   } exp_t;

   exp_t expq[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: owner index (-1 when idle), last owner, beats accepted.
   int m_owner, m_last, m_held, m_sel;

   function automatic int pick(input logic [3:0] r, input int from);
      for (int k = 1; k <= 4; k++)
         if (r[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_sel   = 0;
   endtask

   task automatic cycle(input logic r_rst, input logic [3:0] r_req, input logic [3:0] r_din,
                        input logic r_ready, input logic r_lock);
      exp_t       e;
      logic       v;
      logic [3:0] oth;
      int         p;
      @(posedge clk);
      #1;
      rst        = r_rst;
      req        = r_req;
      din        = r_din;
      dout_ready = r_ready;
      lock       = r_lock;
      v       = (m_owner >= 0) && r_req[m_owner];
      e.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      e.sel   = 2'(m_sel);
      e.valid = v;
      e.dout  = r_din[m_sel];
      expq.push_back(e);
      if (r_rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         p = pick(r_req, m_last);
         if (p >= 0) begin
            m_owner = p; m_last = p; m_sel = p; m_held = 0;
         end
      end else begin
         if (v && r_ready && m_held < MAXH) m_held++;
         oth = r_req & ~4'(1 << m_owner);
         if (!(v && !r_ready) &&
             (!v || (m_held == MAXH && oth != 0 && !(LOCK_EN && r_lock)))) begin
            if (oth != 0) begin
               p = pick(oth, m_owner);
               m_owner = p; m_last = p; m_sel = p; m_held = 0;
            end else begin
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Monitor: pops one expectation per presented cycle, samples at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("gnt", gnt, e.gnt);
            chk("sel", {2'b00, sel}, {2'b00, e.sel});
            chk("dout_valid", {3'b000, dout_valid}, {3'b000, e.valid});
            if (e.valid) chk("dout", {3'b000, dout}, {3'b000, e.dout});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; req = 4'b1111; din = 4'b0000; dout_ready = 1'b0; lock = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      // Reset held with full request, then release.
      cycle(1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0);
      cycle(1'b0, 4'b1111, 4'b0101, 1'b1, 1'b0);
      cycle(1'b0, 4'b1111, 4'b0101, 1'b1, 1'b0);
      // Full contention rotation through two laps.
      for (int i = 0; i < 34; i++) cycle(1'b0, 4'b1111, 4'($urandom), 1'b1, 1'b0);
      // Sole requester keeps the lane.
      cycle(1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 22; i++) cycle(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
      // Backpressure on owner 1 at cnt=3.
      cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
      cycle(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0);
      cycle(1'b0, 4'b0110, 4'b0110, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0110, 4'b0100, 1'b1, 1'b0);
      // Owner drop hand-off, then everyone idles.
      cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
      cycle(1'b0, 4'b0001, 4'b1001, 1'b1, 1'b0);
      cycle(1'b0, 4'b0001, 4'b1001, 1'b1, 1'b0);
      cycle(1'b0, 4'b0001, 4'b1001, 1'b1, 1'b0);
      cycle(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
      cycle(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      // Reset while requester 2 owns the lane.
      cycle(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0);
      cycle(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0);
      cycle(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1111, 4'b1010, 1'b1, 1'b0);
      // Lock holds owner 0 beyond the hold limit (no effect without the macro).
      cycle(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, 4'b0011, 1'b1, 1'b0);
      // Random traffic.
      for (int blk = 0; blk < 40; blk++) begin
         logic [3:0] mask;
         mask = 4'($urandom);
         for (int i = 0; i < 50; i++)
            cycle($urandom_range(0, 99) == 0, 4'($urandom) & (mask | 4'($urandom)),
                  4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 1-bit mux path between four requesters. It drives the mux select and presents the selected bit on a valid/ready output stream. A per-owner hold counter bounds how long one requester keeps the path while others wait. It sits in front of ALU operand/result muxing wherever several sources contend for one 1-bit lane.

Parameters:
MAX_HOLD, 4, max consecutive accepted beats per owner while another requester is pending (range 1..7)
CNT_W, 3, hold counter width; must hold MAX_HOLD

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; req[i] high = requester i has a bit to send
din  input  4  data bit per requester (din[0]=a … din[3]=d)
gnt  output 4  one-hot grant; all zero in IDLE
sel  output 2  registered mux select = current/last owner index
dout  output 1  din[sel] via mux
dout_valid  output 1  GRANT state && req[sel]
dout_ready  input 1  downstream accept; a transfer (xfer) occurs when dout_valid && dout_ready
lock  input 1  only present with ARB_LOCK_EN

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- States: IDLE, GRANT. Registers: state, sel, ptr (last owner, priority pointer), cnt (CNT_W bits).
- Reset: state=IDLE, sel=0, ptr=3 (first priority goes to requester 0), cnt=0. Hence gnt=0, dout_valid=0, dout=din[0]. Reset overrides everything, including mid-transfer and mid-stall.
- Round-robin pick: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE: if req != 0, then next cycle state=GRANT, sel=pick, ptr=pick, cnt=0. Otherwise stay. Request-to-grant latency is 1 cycle.
- GRANT:
  - gnt = onehot(sel).
  - cnt_next = min(cnt + xfer, MAX_HOLD).
  - stall = dout_valid && !dout_ready. No owner change during a stall; valid and sel must stay stable.
  - release = !stall && (!req[sel] || (cnt_next == MAX_HOLD && (req & ~onehot(sel)) != 0)).
  - On release, if any other requester is pending: sel=pick (ptr=sel first, so the current owner is lowest priority) and cnt=0. There is no bubble cycle between owners.
  - On release with no other requester pending: state=IDLE.
  - Otherwise cnt=cnt_next.
- A sole requester keeps the grant indefinitely; cnt saturates at MAX_HOLD.
- Simultaneous events:
  - Owner drops req in the same cycle a new request arrives: hand-off per pick; the new requester is eligible.
  - All four request: strict rotation 0→1→2→3→0.
- dout is combinational from registered sel. It is don't-care when dout_valid=0.

Optional Feature:
ARB_LOCK_EN
- Defined: adds input lock. While lock=1 in GRANT, the MAX_HOLD rotation term is suppressed; release occurs only when the owner drops req. lock is ignored in IDLE.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux4_arb_pkg:
  - state encoding (IDLE=0, GRANT=1)
  - NUM_REQ=4, SEL_W=2
  - onehot-from-index function
- Sub-module rr_pick4, combinational: inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any.
- The datapath instantiates the existing mux_4to1_1b with (din[0], din[1], din[2], din[3], sel, dout).

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 → gnt=0000, sel=0, dout_valid=0. First cycle after release: still IDLE; next cycle gnt=0001.
- Sole requester: req=0100, din=0100, dout_ready=1 → one cycle later sel=2, gnt=0100, dout=1, dout_valid=1. Holds for 20 cycles with no release.
- Full contention: req=1111, dout_ready=1, MAX_HOLD=4 → owners 0,1,2,3,0, each exactly 4 xfers, no idle cycle between owners.
- Backpressure: owner 1 with cnt=3 and req=0110; dout_ready=0 for 5 cycles → sel=1 and dout_valid=1 stable throughout. dout_ready=1 for one beat → sel=2 the next cycle.
- Owner drop: owner 0 drops req after 2 xfers while req=1000 → next cycle sel=3, cnt=0. All requests drop → IDLE, gnt=0000.
- Reset mid-grant: rst pulsed while sel=2 in GRANT → next cycle IDLE, outputs at reset values. With req=1111 afterwards, grant returns to requester 0. With ARB_LOCK_EN, lock=1 and req=1111 → owner 0 keeps the grant past 4 xfers until lock=0.
